// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 write engine: FSM encoding, default
// bus timing (in clock cycles) and the instructions that need the long wait.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_EN_HI,
        ST_HOLD,
        ST_WAIT
    } lcd_state_e;

    localparam int T_SETUP_DEF     = 2;
    localparam int T_EN_DEF        = 25;
    localparam int T_HOLD_DEF      = 2;
    localparam int T_WAIT_DEF      = 2000;
    localparam int T_WAIT_LONG_DEF = 82000;
    localparam int FIFO_DEPTH_DEF  = 4;
    localparam int CNT_W_MIN       = 17;

    localparam logic [7:0] LCD_CLEAR = 8'h01;
    localparam logic [7:0] LCD_HOME  = 8'h02;

    // Clear and home are the only instructions with a multi-millisecond execution time.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && ((data == LCD_CLEAR) || (data == LCD_HOME));
    endfunction

endpackage

// File: rtl/lcd_if.sv
// Valid/ready write-request channel into the LCD write engine.
interface lcd_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_rs;
    logic [7:0] cmd_data;

    modport master (output cmd_valid, output cmd_rs, output cmd_data, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_rs, input cmd_data, output cmd_ready);
endinterface

// File: rtl/lcd_cmd_fifo.sv
// Request queue for the LCD engine; pointers carry one extra bit so that a
// full queue and an empty queue have different encodings.
module lcd_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en_i,
    input  logic [WIDTH-1:0]       wdata_i,
    output logic                   full_o,
    input  logic                   rd_en_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);
    typedef logic [AW:0] ptr_t;

    ptr_t             wr_ptr_q, wr_ptr_d;
    ptr_t             rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push, pop;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign push    = wr_en_i && !full_o;
    assign pop     = rd_en_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q + ptr_t'(push);
        rd_ptr_d = rd_ptr_q + ptr_t'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/lcd_write_engine.sv
// HD44780 write-only bus sequencer: queued {rs, data} requests are replayed
// as setup / enable-strobe / hold / execution-wait cycles from one down-counter.
module lcd_write_engine
    import lcd_pkg::*;
#(
    parameter int T_SETUP     = T_SETUP_DEF,
    parameter int T_EN        = T_EN_DEF,
    parameter int T_HOLD      = T_HOLD_DEF,
    parameter int T_WAIT      = T_WAIT_DEF,
    parameter int T_WAIT_LONG = T_WAIT_LONG_DEF,
    parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF
) (
    input  logic       clk,
    input  logic       rst,
    lcd_if.slave       cmd,
    output logic       busy,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en
);
    localparam int FIFO_AW = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = ($clog2(T_WAIT_LONG + 1) > CNT_W_MIN) ? $clog2(T_WAIT_LONG + 1) : CNT_W_MIN;
    typedef logic [CNT_W-1:0] cnt_t;

    lcd_state_e       state_q, state_d;
    cnt_t             cnt_q, cnt_d;
    logic [7:0]       lcd_data_q, lcd_data_d;
    logic             lcd_rs_q, lcd_rs_d;
    logic             lcd_en_q, lcd_en_d;
    logic             fifo_full, fifo_empty, fifo_pop;
    logic [8:0]       fifo_head;
    logic [FIFO_AW:0] fifo_count;

    lcd_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (9)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en_i (cmd.cmd_valid),
        .wdata_i ({cmd.cmd_rs, cmd.cmd_data}),
        .full_o  (fifo_full),
        .rd_en_i (fifo_pop),
        .rdata_o (fifo_head),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign cmd.cmd_ready = !fifo_full;
    assign busy          = (fifo_count != '0) || (state_q != ST_IDLE);
    assign lcd_data      = lcd_data_q;
    assign lcd_rs        = lcd_rs_q;
    assign lcd_en        = lcd_en_q;
    assign lcd_rw        = 1'b0;

    // Each state loads the counter with its own duration and leaves when it reaches 1.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lcd_data_d = lcd_data_q;
        lcd_rs_d   = lcd_rs_q;
        lcd_en_d   = lcd_en_q;
        fifo_pop   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop               = 1'b1;
                    {lcd_rs_d, lcd_data_d} = fifo_head;
                    cnt_d                  = cnt_t'(T_SETUP);
                    state_d                = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_q == cnt_t'(1)) begin
                    lcd_en_d = 1'b1;
                    cnt_d    = cnt_t'(T_EN);
                    state_d  = ST_EN_HI;
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            ST_EN_HI: begin
                if (cnt_q == cnt_t'(1)) begin
                    lcd_en_d = 1'b0;
                    cnt_d    = cnt_t'(T_HOLD);
                    state_d  = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            ST_HOLD: begin
                if (cnt_q == cnt_t'(1)) begin
                    cnt_d   = is_long_cmd(lcd_rs_q, lcd_data_q) ? cnt_t'(T_WAIT_LONG) : cnt_t'(T_WAIT);
                    state_d = ST_WAIT;
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            ST_WAIT: begin
                if (cnt_q == cnt_t'(1)) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            default: begin
                cnt_d    = '0;
                lcd_en_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            lcd_data_q <= 8'h00;
            lcd_rs_q   <= 1'b0;
            lcd_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lcd_data_q <= lcd_data_d;
            lcd_rs_q   <= lcd_rs_d;
            lcd_en_q   <= lcd_en_d;
        end
    end

endmodule

// File: tb/tb_lcd_write_engine.sv
// Bench for lcd_write_engine with shortened execution waits; a bus monitor
// pops a scoreboard on every enable strobe and checks strobe/hold timing.
module tb_lcd_write_engine;
    import lcd_pkg::*;

    localparam int TS = 2;
    localparam int TE = 25;
    localparam int TH = 2;
    localparam int TW = 40;
    localparam int TWL = 200;
    localparam int DEPTH = 4;
    localparam int PUSH_BOUND = 1000;
    localparam int IDLE_BOUND = 2000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       busy, lcd_rs, lcd_rw, lcd_en;
    logic [7:0] lcd_data;

    lcd_if cmd_if ();

    lcd_write_engine #(
        .T_SETUP     (TS),
        .T_EN        (TE),
        .T_HOLD      (TH),
        .T_WAIT      (TW),
        .T_WAIT_LONG (TWL),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd      (cmd_if),
        .busy     (busy),
        .lcd_data (lcd_data),
        .lcd_rs   (lcd_rs),
        .lcd_rw   (lcd_rw),
        .lcd_en   (lcd_en)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         tests = 0;
    int         fails = 0;
    logic [8:0] sb[$];
    int         rises = 0;
    int         last_rise = -1;
    int         last_fall = -1;
    int         last_gap = -1;
    int         rw_bad = 0;
    int         stab_bad = 0;
    int         hold_cnt = 0;
    int         prev_w = 0;
    bit         have_fall = 1'b0;
    logic       prev_en = 1'b0;
    logic [8:0] locked = '0;

    typedef struct {
        logic       rs;
        logic [7:0] d;
        int         w;
    } vec_t;
    vec_t vt[8];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual=%0d (0x%0h) required=%0d (0x%0h)", name, act, act, req, req);
        end
    endfunction

    function automatic void check_ge(input string name, input int act, input int req);
        tests++;
        if (act < req) begin
            fails++;
            $display("FAIL %s: actual=%0d required>=%0d", name, act, req);
        end
    endfunction

    function automatic int wait_of(input logic [8:0] e);
        return (!e[8] && (e[7:0] == 8'h01 || e[7:0] == 8'h02)) ? TWL : TW;
    endfunction

    // Bus monitor, sampled on the falling edge.
    always @(negedge clk) begin : mon
        logic [8:0] e;
        if (lcd_rw !== 1'b0) rw_bad++;
        if (rst) begin
            prev_en   = 1'b0;
            hold_cnt  = 0;
            have_fall = 1'b0;
        end else begin
            if (lcd_en && !prev_en) begin
                rises++;
                last_rise = cyc;
                locked    = {lcd_rs, lcd_data};
                if (sb.size() == 0) begin
                    check("unexpected_en_pulse", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("sb_order", 32'({lcd_rs, lcd_data}), 32'(e));
                    if (have_fall) begin
                        last_gap = cyc - last_fall;
                        check_ge("gap_min", last_gap, TH + prev_w + 1 + TS);
                    end
                    prev_w = wait_of(e);
                end
            end else if (lcd_en) begin
                if ({lcd_rs, lcd_data} !== locked) stab_bad++;
            end else if (prev_en) begin
                check("en_width", cyc - last_rise, TE);
                last_fall = cyc;
                have_fall = 1'b1;
                hold_cnt  = TH;
                if ({lcd_rs, lcd_data} !== locked) stab_bad++;
            end else if (hold_cnt > 0) begin
                if ({lcd_rs, lcd_data} !== locked) stab_bad++;
                hold_cnt--;
            end
            prev_en = lcd_en;
        end
    end

    task automatic push(input logic rs, input logic [7:0] d, output int acc);
        int n = 0;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_rs    = rs;
        cmd_if.cmd_data  = d;
        while (!cmd_if.cmd_ready && n < PUSH_BOUND) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_if.cmd_ready) begin
            check("push_timeout", 32'd0, 32'd1);
            cmd_if.cmd_valid = 1'b0;
            acc = -1;
            return;
        end
        sb.push_back({rs, d});
        @(posedge clk);
        #1;
        acc = cyc;
    endtask

    task automatic idle_in();
        cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(output int c);
        int n = 0;
        @(negedge clk);
        while (busy && n < IDLE_BOUND) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", 32'd0, 32'd1);
        c = cyc;
    endtask

    task automatic wait_rises(input int target);
        int n = 0;
        while (rises < target && n < IDLE_BOUND) begin
            @(negedge clk);
            n++;
        end
        if (rises < target) check("rise_timeout", 32'(rises), 32'(target));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int acc, c, r0, r1;
        int accs[5];

        vt[0] = '{1'b1, 8'h41, TW};
        vt[1] = '{1'b0, 8'h01, TWL};
        vt[2] = '{1'b0, 8'h02, TWL};
        vt[3] = '{1'b1, 8'h01, TW};
        vt[4] = '{1'b1, 8'h02, TW};
        vt[5] = '{1'b0, 8'h03, TW};
        vt[6] = '{1'b0, 8'h38, TW};
        vt[7] = '{1'b1, 8'hFF, TW};

        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_rs    = 1'b0;
        cmd_if.cmd_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_lcd_data", 32'(lcd_data), 32'h00);
        check("rst_lcd_rs", 32'(lcd_rs), 32'd0);
        check("rst_lcd_en", 32'(lcd_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cmd_ready", 32'(cmd_if.cmd_ready), 32'd1);

        // Release reset with the first request already presented.
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            push(vt[i].rs, vt[i].d, acc);
            idle_in();
            @(negedge clk);
            check("busy_after_accept", 32'(busy), 32'd1);
            @(negedge clk);
            check("pop_latency_data", 32'({lcd_rs, lcd_data}), 32'({vt[i].rs, vt[i].d}));
            check("en_low_in_setup", 32'(lcd_en), 32'd0);
            wait_idle(c);
            check("en_rise_time", last_rise, acc + 1 + TS);
            check("busy_low_time", c, acc + 1 + TS + TE + TH + vt[i].w);
            repeat (2) @(negedge clk);
        end

        // Clear followed by a data byte: the data byte waits out the long delay.
        push(1'b0, 8'h01, acc);
        push(1'b1, 8'h43, acc);
        idle_in();
        wait_idle(c);
        check("clear_gap", last_gap, TH + TWL + 1 + TS);

        // Fill the queue while the engine is busy with a priming entry.
        r0 = rises;
        push(1'b1, 8'h30, acc);
        idle_in();
        wait_rises(r0 + 1);
        for (int i = 0; i < 5; i++) begin
            push(1'b1, 8'h50 + 8'(i), accs[i]);
            if (i == 3) check("ready_low_when_full", 32'(cmd_if.cmd_ready), 32'd0);
        end
        idle_in();
        check("fill_b2b_2", accs[1], accs[0] + 1);
        check("fill_b2b_4", accs[3], accs[0] + 3);
        check("fifth_accept", accs[4], last_fall + TH + TW + 2);
        wait_idle(c);
        check("fill_sb_empty", 32'(sb.size()), 32'd0);

        // Push on the same edge as a pop with two entries queued.
        push(1'b1, 8'h60, acc);
        push(1'b1, 8'h61, acc);
        push(1'b1, 8'h62, acc);
        idle_in();
        c = 0;
        @(negedge clk);
        while (dut.state_q != ST_IDLE && c < IDLE_BOUND) begin
            @(negedge clk);
            c++;
        end
        push(1'b1, 8'h63, acc);
        idle_in();
        check("pushpop_count", 32'(dut.u_fifo.count_o), 32'd2);
        check("pushpop_ready", 32'(cmd_if.cmd_ready), 32'd1);
        check("pushpop_popped", 32'({lcd_rs, lcd_data}), 32'({1'b1, 8'h61}));
        wait_idle(c);

        // Reset in the middle of the second strobe of three.
        r0 = rises;
        push(1'b1, 8'h70, acc);
        push(1'b1, 8'h71, acc);
        push(1'b1, 8'h72, acc);
        idle_in();
        wait_rises(r0 + 2);
        repeat (5) @(negedge clk);
        check("en_high_before_rst", 32'(lcd_en), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_en", 32'(lcd_en), 32'd0);
        check("rst_async_data", 32'({lcd_rs, lcd_data}), 32'd0);
        check("rst_async_busy", 32'(busy), 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        r1 = rises;
        repeat (TS + TE + TH + TWL + 20) @(negedge clk);
        check("post_rst_no_pulse", 32'(rises), 32'(r1));
        check("post_rst_busy", 32'(busy), 32'd0);

        // Random stream.
        for (int i = 0; i < 200; i++) begin
            push(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), acc);
            if ($urandom_range(0, 3) == 0) begin
                idle_in();
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end
        idle_in();
        wait_idle(c);

        check("rw_always_0", 32'(rw_bad), 32'd0);
        check("data_stable", 32'(stab_bad), 32'd0);
        check("sb_empty_end", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
